irq_ctl: RTL and testbench
==========================

# irq_ctl

Interrupt controller that drives the `irq` input of the single-cycle MIPS control unit and tracks the processor's acknowledgement through `pc31`, the PC bit that marks handler/kernel space. It latches rising edges on external sources, applies a software mask, and selects the lowest-index enabled source. It asserts `irq` until the core enters handler space, then holds off further requests until the handler returns (no nesting). It exposes cause, pending, overrun and timeout status for the handler to read.

## Interface
- `N_SRC`, 4: number of interrupt sources (1..8).
- `ACK_TIMEOUT`, 16: cycles `irq` may stay high without acknowledgement before it is abandoned.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `src` in N_SRC: interrupt request lines, synchronous to `clk`; a rising edge is an event.
- `pc31` in 1: PC[31] of the core; 1 = executing in handler space.
- `mask_we` in 1: load `mask` from `mask_wdata` this cycle.
- `mask_wdata` in N_SRC: new enable mask; 1 = enabled.
- `clr_we` in 1: write-one-to-clear strobe for `pending`, `ovf` and `timeout_err`.
- `clr_wdata` in N_SRC+1: bits [N_SRC-1:0] clear pending/ovf per source; bit N_SRC clears `timeout_err`.
- `irq` out 1: interrupt request to the control unit.
- `cause` out $clog2(N_SRC) (min 1): index of the source being signalled or serviced.
- `cause_valid` out 1: high in ASSERT and SERVICE.
- `pending` out N_SRC: latched, not-yet-dispatched events.
- `mask` out N_SRC: current enable mask.
- `ovf` out N_SRC: sticky; an event arrived while that source was already pending.
- `timeout_err` out 1: sticky; an ASSERT timed out.

## Operation
- Edge detect: `src_q` is `src` registered. `rise = src & ~src_q`.
- `pending[i]`: set on `rise[i]`, cleared by `clr_wdata[i]` under `clr_we`, and cleared on dispatch (ASSERT→SERVICE, i = `cause`). If set and clear occur in the same cycle, set wins.
- `ovf[i]`: set when `rise[i]` occurs while `pending[i]` is already 1. Cleared only by clr.
- Selection: `sel` is the lowest index i with `pending[i] & mask[i]`. `any` is the OR of `pending & mask`.
- FSM states: IDLE, ASSERT, SERVICE.
  - IDLE→ASSERT when `any & ~pc31`. `cause` latches `sel`. The timeout counter loads 0.
  - ASSERT→SERVICE when `pc31`=1. Clears `pending[cause]`.
  - ASSERT→IDLE when `pending[cause]` or `mask[cause]` drops to 0 (software withdrawal). No error.
  - ASSERT→IDLE when the counter reaches ACK_TIMEOUT-1 with `pc31`=0. Sets `timeout_err`. Pending stays set, so the source is retried.
  - SERVICE→IDLE when `pc31`=0 (handler returned).
- `irq` = (state==ASSERT), registered. `cause` holds its value in SERVICE.
- If `pc31` is already high in IDLE, no request is raised; the controller waits for `pc31`=0.
- A mask write takes effect for selection in the next cycle. Masking does not clear pending.

## Timing
- Reset values: state IDLE, `irq` 0, `cause` 0, `cause_valid` 0, `pending` 0, `mask` 0, `ovf` 0, `timeout_err` 0, `src_q` 0, counter 0.
- Latency:
  - `src[i]` first sampled high at edge k → `pending[i]`=1 after edge k.
  - `irq`=1 after edge k+1 when enabled, IDLE and `pc31`=0.
- Acknowledge: `pc31` sampled 1 at edge a → `irq`=0 and `pending[cause]`=0 after edge a.
- Timeout: `irq` stays high for exactly ACK_TIMEOUT cycles when never acknowledged.
- Simultaneous rises: lowest index is served first. Others remain pending and are dispatched in later IDLE windows, in index order.
- Reset mid-ASSERT or mid-SERVICE: everything returns to reset values next edge; in-flight events are lost.

## Structure
- Package `irq_pkg`: state enum `irq_state_t {IDLE, ASSERT, SERVICE}`, and default constants `IRQ_N_SRC`=4 and `IRQ_ACK_TIMEOUT`=16.
- Sub-module `irq_prio_enc`, combinational: inputs `req[N_SRC]`; outputs `idx` and `any`; lowest index wins.

## Test plan
- Basic dispatch: mask=4'b0010, pulse src[1] → `irq` high two edges later with `cause`=1. Raise `pc31` → `irq` low, pending=0. Drop `pc31` → IDLE.
- Priority: mask=4'hF, src[3] and src[0] rise together → `cause`=0 first. After a `pc31` high/low cycle, `cause`=3 is asserted.
- Masking: mask=0, pulse src[2] → pending=4'b0100, `irq` stays 0. Write mask=4'b0100 → `irq`=1 two edges after the write.
- Overrun and clear: src[1] rises twice while pending → `ovf`=4'b0010. Clear with `clr_wdata`=5'b00010 → pending=0, `ovf`=0. Same-cycle rise+clear → pending stays 1.
- Timeout: hold `pc31`=0 after an enabled event → `irq` high exactly 16 cycles, `timeout_err`=1, pending still 1, `irq` re-asserts.
- Reset mid-SERVICE: assert `reset` for one cycle → all outputs at reset values. A subsequent event is served normally.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_pkg: shared state encoding and default sizing for irq_ctl    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

   localparam int IRQ_N_SRC       = 4;
   localparam int IRQ_ACK_TIMEOUT = 16;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_prio_enc: combinational priority encoder, lowest index wins  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module irq_prio_enc #(
   parameter int N_SRC = 4,
   parameter int IDX_W = 2
)(
   input  logic [N_SRC-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan downward so the lowest set index is the last assignment.
   always_comb begin
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) idx = i[IDX_W-1:0];
      end
   end

   assign any = |req;

endmodule
`default_nettype wire

// File: rtl/irq_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_ctl: edge-latched, masked, non-nesting interrupt controller  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module irq_ctl
   import irq_pkg::*;
#(
   parameter int N_SRC       = IRQ_N_SRC,
   parameter int ACK_TIMEOUT = IRQ_ACK_TIMEOUT,
   localparam int CAUSE_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [N_SRC-1:0]   src,
   input  logic               pc31,
   input  logic               mask_we,
   input  logic [N_SRC-1:0]   mask_wdata,
   input  logic               clr_we,
   input  logic [N_SRC:0]     clr_wdata,
   output logic               irq,
   output logic [CAUSE_W-1:0] cause,
   output logic               cause_valid,
   output logic [N_SRC-1:0]   pending,
   output logic [N_SRC-1:0]   mask,
   output logic [N_SRC-1:0]   ovf,
   output logic               timeout_err
);

   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ACK_TIMEOUT - 1);

   irq_state_t         r_state;
   irq_state_t         w_state_nxt;
   logic [N_SRC-1:0]   r_src_q;
   logic [N_SRC-1:0]   r_pending;
   logic [N_SRC-1:0]   r_mask;
   logic [N_SRC-1:0]   r_ovf;
   logic               r_timeout_err;
   logic [CAUSE_W-1:0] r_cause;
   logic [CNT_W-1:0]   r_cnt;

   logic [N_SRC-1:0]   w_rise;
   logic [N_SRC-1:0]   w_clr;
   logic [N_SRC-1:0]   w_disp_clr;
   logic [CAUSE_W-1:0] w_sel;
   logic               w_any;
   logic               w_live;
   logic               w_cnt_done;
   logic               w_launch;
   logic               w_dispatch;
   logic               w_timeout;

   assign w_rise     = src & ~r_src_q;
   assign w_clr      = clr_we ? clr_wdata[N_SRC-1:0] : '0;
   assign w_live     = r_pending[r_cause] & r_mask[r_cause];
   assign w_cnt_done = (r_cnt == c_cnt_last);
   assign w_disp_clr = w_dispatch ? (N_SRC'(1) << r_cause) : '0;

   irq_prio_enc #(
      .N_SRC (N_SRC),
      .IDX_W (CAUSE_W)
   ) u_prio_enc (
      .req (r_pending & r_mask),
      .idx (w_sel),
      .any (w_any)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any && !pc31) w_state_nxt = ASSERT;
         ASSERT: begin
            if (pc31)            w_state_nxt = SERVICE;
            else if (!w_live)    w_state_nxt = IDLE;
            else if (w_cnt_done) w_state_nxt = IDLE;
         end
         SERVICE: if (!pc31) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_launch    = (r_state == IDLE) && w_any && !pc31;
      w_dispatch  = (r_state == ASSERT) && pc31;
      w_timeout   = (r_state == ASSERT) && !pc31 && w_live && w_cnt_done;
      irq         = (r_state == ASSERT);
      cause_valid = (r_state == ASSERT) || (r_state == SERVICE);
   end

   // New events are OR'd in last so a same-cycle rise beats any clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_src_q       <= '0;
         r_pending     <= '0;
         r_mask        <= '0;
         r_ovf         <= '0;
         r_timeout_err <= 1'b0;
         r_cause       <= '0;
         r_cnt         <= '0;
      end else begin
         r_src_q       <= src;
         r_pending     <= (r_pending & ~w_clr & ~w_disp_clr) | w_rise;
         r_ovf         <= (r_ovf & ~w_clr) | (w_rise & r_pending);
         r_timeout_err <= (r_timeout_err & ~(clr_we & clr_wdata[N_SRC])) | w_timeout;
         if (mask_we) r_mask <= mask_wdata;
         if (w_launch) begin
            r_cause <= w_sel;
            r_cnt   <= '0;
         end else if (r_state == ASSERT && !w_cnt_done) begin
            r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign cause       = r_cause;
   assign pending     = r_pending;
   assign mask        = r_mask;
   assign ovf         = r_ovf;
   assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_irq_ctl: directed self-checking bench for irq_ctl             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_irq_ctl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] src = '0;
   logic       pc31 = 1'b0;
   logic       mask_we = 1'b0;
   logic [3:0] mask_wdata = '0;
   logic       clr_we = 1'b0;
   logic [4:0] clr_wdata = '0;
   logic       irq;
   logic [1:0] cause;
   logic       cause_valid;
   logic [3:0] pending;
   logic [3:0] mask;
   logic [3:0] ovf;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   irq_ctl #(.N_SRC(4), .ACK_TIMEOUT(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .src         (src),
      .pc31        (pc31),
      .mask_we     (mask_we),
      .mask_wdata  (mask_wdata),
      .clr_we      (clr_we),
      .clr_wdata   (clr_wdata),
      .irq         (irq),
      .cause       (cause),
      .cause_valid (cause_valid),
      .pending     (pending),
      .mask        (mask),
      .ovf         (ovf),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [3:0] m);
      mask_we = 1'b1; mask_wdata = m;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({irq, cause, cause_valid, pending, mask, ovf, timeout_err} !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0000",
                  {irq, cause, cause_valid, pending, mask, ovf, timeout_err});
      end
   endtask

   task automatic test_basic();
      write_mask(4'b0010);
      checks++;
      if (mask !== 4'b0010) begin errors++; $display("FAIL basic_mask: got %b expected 0010", mask); end
      src = 4'b0010; tick();
      checks++;
      if (pending !== 4'b0010 || irq !== 1'b0) begin
         errors++; $display("FAIL basic_latch: pending %b irq %b expected 0010 0", pending, irq);
      end
      src = 4'b0000; tick();
      checks++;
      if (irq !== 1'b1 || cause !== 2'd1 || cause_valid !== 1'b1) begin
         errors++; $display("FAIL basic_irq: irq %b cause %0d cv %b expected 1 1 1", irq, cause, cause_valid);
      end
      pc31 = 1'b1; tick();
      checks++;
      if (irq !== 1'b0 || pending !== 4'b0000 || cause_valid !== 1'b1 || cause !== 2'd1) begin
         errors++; $display("FAIL basic_ack: irq %b pending %b cv %b cause %0d expected 0 0000 1 1",
                            irq, pending, cause_valid, cause);
      end
      tick();
      pc31 = 1'b0; tick();
      checks++;
      if (cause_valid !== 1'b0 || irq !== 1'b0) begin
         errors++; $display("FAIL basic_return: cv %b irq %b expected 0 0", cause_valid, irq);
      end
   endtask

   task automatic test_priority();
      write_mask(4'hF);
      src = 4'b1001; tick();
      src = 4'b0000; tick();
      checks++;
      if (irq !== 1'b1 || cause !== 2'd0) begin
         errors++; $display("FAIL prio_first: irq %b cause %0d expected 1 0", irq, cause);
      end
      pc31 = 1'b1; tick();
      checks++;
      if (pending !== 4'b1000) begin errors++; $display("FAIL prio_remain: got %b expected 1000", pending); end
      pc31 = 1'b0; tick();
      tick();
      checks++;
      if (irq !== 1'b1 || cause !== 2'd3) begin
         errors++; $display("FAIL prio_second: irq %b cause %0d expected 1 3", irq, cause);
      end
      pc31 = 1'b1; tick();
      pc31 = 1'b0; tick();
   endtask

   task automatic test_masking();
      write_mask(4'b0000);
      src = 4'b0100; tick();
      src = 4'b0000; tick(); tick();
      checks++;
      if (pending !== 4'b0100 || irq !== 1'b0) begin
         errors++; $display("FAIL mask_hold: pending %b irq %b expected 0100 0", pending, irq);
      end
      write_mask(4'b0100);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL mask_early: irq %b expected 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1 || cause !== 2'd2) begin
         errors++; $display("FAIL mask_enable: irq %b cause %0d expected 1 2", irq, cause);
      end
      pc31 = 1'b1; tick();
      pc31 = 1'b0; tick();
   endtask

   task automatic test_overrun_clear();
      write_mask(4'b0000);
      src = 4'b0010; tick();
      src = 4'b0000; tick();
      src = 4'b0010; tick();
      src = 4'b0000;
      checks++;
      if (ovf !== 4'b0010 || pending !== 4'b0010) begin
         errors++; $display("FAIL ovf_set: ovf %b pending %b expected 0010 0010", ovf, pending);
      end
      clr_we = 1'b1; clr_wdata = 5'b00010; tick();
      clr_we = 1'b0;
      checks++;
      if (ovf !== 4'b0000 || pending !== 4'b0000) begin
         errors++; $display("FAIL ovf_clear: ovf %b pending %b expected 0000 0000", ovf, pending);
      end
      src = 4'b0010; tick();
      src = 4'b0000; tick();
      src = 4'b0010; clr_we = 1'b1; clr_wdata = 5'b00010; tick();
      src = 4'b0000; clr_we = 1'b0;
      checks++;
      if (pending !== 4'b0010) begin errors++; $display("FAIL set_wins: pending %b expected 0010", pending); end
      clr_we = 1'b1; clr_wdata = 5'b11111; tick();
      clr_we = 1'b0;
   endtask

   task automatic test_timeout();
      int high_cnt;
      write_mask(4'b0001);
      src = 4'b0001; tick();
      src = 4'b0000; tick();
      high_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (irq !== 1'b1) break;
         high_cnt++;
         tick();
      end
      checks++;
      if (high_cnt != 16) begin errors++; $display("FAIL timeout_len: irq high %0d cycles expected 16", high_cnt); end
      checks++;
      if (timeout_err !== 1'b1 || pending !== 4'b0001) begin
         errors++; $display("FAIL timeout_flag: terr %b pending %b expected 1 0001", timeout_err, pending);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || cause !== 2'd0) begin
         errors++; $display("FAIL timeout_retry: irq %b cause %0d expected 1 0", irq, cause);
      end
      pc31 = 1'b1; tick();
      pc31 = 1'b0; clr_we = 1'b1; clr_wdata = 5'b10000; tick();
      clr_we = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: terr %b expected 0", timeout_err); end
   endtask

   task automatic test_reset_mid_service();
      write_mask(4'b0100);
      src = 4'b0100; tick();
      src = 4'b0000; tick();
      pc31 = 1'b1; tick();
      checks++;
      if (cause_valid !== 1'b1 || irq !== 1'b0) begin
         errors++; $display("FAIL svc_enter: cv %b irq %b expected 1 0", cause_valid, irq);
      end
      src = 4'b0001;
      reset = 1'b1; tick();
      reset = 1'b0; pc31 = 1'b0; src = 4'b0000;
      checks++;
      if ({irq, cause, cause_valid, pending, mask, ovf, timeout_err} !== 16'h0) begin
         errors++; $display("FAIL svc_reset: got %h expected 0000",
                            {irq, cause, cause_valid, pending, mask, ovf, timeout_err});
      end
      write_mask(4'b1000);
      src = 4'b1000; tick();
      src = 4'b0000; tick();
      checks++;
      if (irq !== 1'b1 || cause !== 2'd3) begin
         errors++; $display("FAIL post_reset: irq %b cause %0d expected 1 3", irq, cause);
      end
      pc31 = 1'b1; tick();
      pc31 = 1'b0; tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_masking();
      test_overrun_clear();
      test_timeout();
      test_reset_mid_service();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
